// File: rtl/subterranean_duplex_core.sv
// Purpose : Subterranean duplex core. It keeps the 257-bit state and runs one combinational
//           round per command (init, absorb, encrypt, decrypt, squeeze).
// Latency : the command is latched on edge 1; state, buffer_out and core_finish update on edge 2.
// Backpr. : core_free is low for the one busy cycle. start_operation is ignored while busy.
// Ports   : clk, arst (async, active-high)
//           start_operation, operation_type[3:0], buffer_in[31:0], buffer_in_size[1:0]
//           buffer_out[31:0] (registered), core_free, core_finish (1-cycle pulse)
module subterranean_duplex_core (
  input  logic        clk,
  input  logic        arst,
  input  logic        start_operation,
  input  logic [3:0]  operation_type,
  input  logic [31:0] buffer_in,
  input  logic [1:0]  buffer_in_size,
  output logic [31:0] buffer_out,
  output logic        core_free,
  output logic        core_finish
);

  localparam int N = 257;
  // 12^4 mod 257. Successive powers give the absorb/extract taps.
  localparam int TAP_STEP = 176;

  typedef enum logic {ST_IDLE, ST_BUSY} fsm_t;

  fsm_t        fsm;
  logic [256:0] s;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_dat;
  logic [1:0]  cmd_size;

  logic [256:0] s_nxt;
  logic [31:0]  out_nxt;
  logic [31:0]  z;
  logic [31:0]  msk;
  logic [31:0]  x;
  logic [32:0]  sigma;

  // One round in order: chi, iota, theta, pi.
  function automatic logic [256:0] permute(input logic [256:0] st);
    logic [256:0] a, b, c;
    for (int i = 0; i < N; i++)
      a[9'(i)] = st[9'(i)] ^ (~st[9'((i + 1) % N)] & st[9'((i + 2) % N)]);
    a[0] = ~a[0];
    for (int i = 0; i < N; i++)
      b[9'(i)] = a[9'(i)] ^ a[9'((i + 3) % N)] ^ a[9'((i + 8) % N)];
    for (int i = 0; i < N; i++)
      c[9'(i)] = b[9'((12 * i) % N)];
    return c;
  endfunction

  // Each output bit folds a tap with its mirror at -tap mod 257.
  function automatic logic [31:0] extract(input logic [256:0] st);
    logic [31:0] r;
    int p;
    p = 1;
    for (int i = 0; i < 32; i++) begin
      r[5'(i)] = st[9'(p)] ^ st[9'(N - p)];
      p = (p * TAP_STEP) % N;
    end
    return r;
  endfunction

  function automatic logic [256:0] absorb(input logic [256:0] st, input logic [32:0] sg);
    logic [256:0] r;
    int p;
    r = st;
    p = 1;
    for (int j = 0; j < 33; j++) begin
      r[9'(p)] = r[9'(p)] ^ sg[6'(j)];
      p = (p * TAP_STEP) % N;
    end
    return r;
  endfunction

  function automatic logic [31:0] byte_mask(input logic [1:0] n);
    logic [31:0] m;
    case (n)
      2'd0:    m = 32'h0000_0000;
      2'd1:    m = 32'h0000_00FF;
      2'd2:    m = 32'h0000_FFFF;
      default: m = 32'h00FF_FFFF;
    endcase
    return m;
  endfunction

  // Incomplete pad: keep n bytes and place the terminating 1 right above them.
  function automatic logic [32:0] pad_inc(input logic [31:0] d, input logic [1:0] n);
    return {1'b0, d & byte_mask(n)} | (33'd1 << {n, 3'b000});
  endfunction

  always_comb begin
    z       = extract(s);
    msk     = byte_mask(cmd_size);
    x       = cmd_dat ^ z;
    sigma   = 33'd1;
    out_nxt = buffer_out;
    s_nxt   = s;
    case (cmd_op)
      3'd1: sigma = {1'b1, cmd_dat};
      3'd2: sigma = pad_inc(cmd_dat, cmd_size);
      3'd3: begin
        out_nxt = x;
        sigma   = {1'b1, cmd_dat};
      end
      3'd4: begin
        out_nxt = x & msk;
        sigma   = pad_inc(cmd_dat, cmd_size);
      end
      3'd5: begin
        out_nxt = x;
        sigma   = {1'b1, x};
      end
      3'd6: begin
        out_nxt = x & msk;
        sigma   = pad_inc(x, cmd_size);
      end
      3'd7: begin
        out_nxt = z;
        sigma   = 33'd1;
      end
      default: ;
    endcase
    if (cmd_op == 3'd0) begin
      s_nxt   = '0;
      out_nxt = '0;
    end else begin
      s_nxt = absorb(permute(s), sigma);
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      fsm         <= ST_IDLE;
      s           <= '0;
      buffer_out  <= '0;
      core_free   <= 1'b1;
      core_finish <= 1'b0;
      cmd_op      <= '0;
      cmd_dat     <= '0;
      cmd_size    <= '0;
    end else begin
      case (fsm)
        ST_IDLE: begin
          core_finish <= 1'b0;
          // Codes 8-15 never leave idle, so they produce no finish pulse.
          if (start_operation && !operation_type[3]) begin
            cmd_op    <= operation_type[2:0];
            cmd_dat   <= buffer_in;
            cmd_size  <= buffer_in_size;
            core_free <= 1'b0;
            fsm       <= ST_BUSY;
          end
        end
        default: begin
          s           <= s_nxt;
          buffer_out  <= out_nxt;
          core_finish <= 1'b1;
          core_free   <= 1'b1;
          fsm         <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_subterranean_duplex_core.sv
module tb_subterranean_duplex_core;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        start_operation = 1'b0;
  logic [3:0]  operation_type = '0;
  logic [31:0] buffer_in = '0;
  logic [1:0]  buffer_in_size = '0;
  logic [31:0] buffer_out;
  logic        core_free;
  logic        core_finish;

  always #5 clk = ~clk;

  subterranean_duplex_core dut (
    .clk             (clk),
    .arst            (arst),
    .start_operation (start_operation),
    .operation_type  (operation_type),
    .buffer_in       (buffer_in),
    .buffer_in_size  (buffer_in_size),
    .buffer_out      (buffer_out),
    .core_free       (core_free),
    .core_finish     (core_finish)
  );

  typedef struct {
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t         exp_q[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           busy_cnt = 0;
  logic [256:0] m_s = '0;
  logic [31:0]  m_out = '0;

  localparam logic [31:0] A = 32'h1234_5678;
  localparam logic [31:0] P = 32'hDEAD_BEEF;

  // ---------------- reference model ----------------
  function automatic int tap(input int j);
    int p;
    p = 1;
    for (int k = 0; k < 4 * j; k++) p = (p * 12) % 257;
    return p;
  endfunction

  function automatic logic [256:0] m_perm(input logic [256:0] st);
    logic [256:0] t, u, v;
    for (int i = 0; i < 257; i++)
      t[9'(i)] = st[9'(i)] ^ (~st[9'((i + 1) % 257)] & st[9'((i + 2) % 257)]);
    t[0] = ~t[0];
    for (int i = 0; i < 257; i++)
      u[9'(i)] = t[9'(i)] ^ t[9'((i + 3) % 257)] ^ t[9'((i + 8) % 257)];
    v = '0;
    // 150 is the inverse of 12 mod 257, so v[i] = u[12*i].
    for (int k = 0; k < 257; k++) v[9'((150 * k) % 257)] = u[9'(k)];
    return v;
  endfunction

  function automatic logic [31:0] m_extract(input logic [256:0] st);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[5'(i)] = st[9'(tap(i))] ^ st[9'(257 - tap(i))];
    return r;
  endfunction

  function automatic logic [31:0] m_mask(input logic [1:0] n);
    logic [31:0] r;
    r = 32'h0;
    for (int b = 0; b < 32; b++) if (b < 8 * int'(n)) r[5'(b)] = 1'b1;
    return r;
  endfunction

  function automatic logic [32:0] m_pad(input logic [31:0] d, input logic [1:0] n);
    logic [32:0] r;
    r = {1'b0, d & m_mask(n)};
    r[6'(8 * int'(n))] = 1'b1;
    return r;
  endfunction

  task automatic m_cmd(input logic [3:0] op, input logic [31:0] b, input logic [1:0] n,
                       output logic [31:0] o);
    logic [31:0] z;
    logic [32:0] sg;
    z  = m_extract(m_s);
    o  = m_out;
    sg = 33'd1;
    case (op)
      4'd1: sg = {1'b1, b};
      4'd2: sg = m_pad(b, n);
      4'd3: begin o = b ^ z; sg = {1'b1, b}; end
      4'd4: begin o = (b ^ z) & m_mask(n); sg = m_pad(b, n); end
      4'd5: begin o = b ^ z; sg = {1'b1, o}; end
      4'd6: begin o = (b ^ z) & m_mask(n); sg = m_pad(o, n); end
      4'd7: begin o = z; sg = 33'd1; end
      default: ;
    endcase
    if (op == 4'd0) begin
      m_s = '0;
      o   = '0;
    end else if (op < 4'd8) begin
      m_s = m_perm(m_s);
      for (int j = 0; j < 33; j++) m_s[9'(tap(j))] = m_s[9'(tap(j))] ^ sg[6'(j)];
    end
    m_out = o;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, expv);
    end
  endtask

  // Monitor: pops the scoreboard on every finish pulse and checks the busy window.
  always @(negedge clk) begin
    exp_t e;
    if (arst) begin
      busy_cnt = 0;
    end else begin
      if (core_finish === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_finish: buffer_out=%h with no command pending", buffer_out);
        end else begin
          e = exp_q.pop_front();
          if (buffer_out !== e.val) begin
            n_fail++;
            $display("FAIL %s: buffer_out=%h expected %h", e.tag, buffer_out, e.val);
          end
        end
      end
      if (core_free !== 1'b1) begin
        busy_cnt++;
      end else if (busy_cnt != 0) begin
        n_checks++;
        if (busy_cnt != 1) begin
          n_fail++;
          $display("FAIL busy_window: core_free low %0d cycles expected 1", busy_cnt);
        end
        busy_cnt = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cmd(input string tag, input logic [3:0] op, input logic [31:0] b,
                     input logic [1:0] n, input bit use_hand, input logic [31:0] hand,
                     input bit hold2);
    logic [31:0] mo;
    exp_t e;
    for (int t = 0; t < 20 && core_free !== 1'b1; t++) begin @(posedge clk); #2; end
    if (core_free !== 1'b1) check({tag, "_idle_timeout"}, {31'b0, core_free}, 32'd1);
    m_cmd(op, b, n, mo);
    if (op < 4'd8) begin
      e.val = use_hand ? hand : mo;
      e.tag = tag;
      exp_q.push_back(e);
    end
    start_operation = 1'b1;
    operation_type  = op;
    buffer_in       = b;
    buffer_in_size  = n;
    @(posedge clk); #2;
    if (hold2) begin
      // Second strobe lands in the busy cycle and must be dropped.
      operation_type = 4'd1;
      buffer_in      = 32'hFFFF_FFFF;
      @(posedge clk); #2;
    end
    start_operation = 1'b0;
    if (op < 4'd8) begin
      for (int t = 0; t < 10 && exp_q.size() != 0; t++) begin @(posedge clk); #2; end
      if (exp_q.size() != 0) begin
        check({tag, "_finish_timeout"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
      end
    end else begin
      check({tag, "_core_free"}, {31'b0, core_free}, 32'd1);
      repeat (3) begin @(posedge clk); #2; end
    end
  endtask

  task automatic hand(input string tag, input logic [3:0] op, input logic [31:0] b,
                      input logic [1:0] n, input logic [31:0] expv);
    cmd(tag, op, b, n, 1'b1, expv, 1'b0);
  endtask

  task automatic modl(input string tag, input logic [3:0] op, input logic [31:0] b,
                      input logic [1:0] n);
    cmd(tag, op, b, n, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check("rst_buffer_out", buffer_out, 32'h0);
    check("rst_core_free", {31'b0, core_free}, 32'd1);
    check("rst_core_finish", {31'b0, core_finish}, 32'd0);
    arst = 1'b0;

    // From the zero state: one round leaves bits {0,64,85}, and 64 is extract tap 8.
    // So after one absorb, squeeze = sigma[31:0] ^ 0x100 ^ sigma[32].
    hand("init_a", 0, 0, 0, 32'h0);
    hand("sq_zero", 7, 0, 0, 32'h0);
    hand("sq_second", 7, 0, 0, 32'h0000_0101);
    hand("simple_keeps_out", 1, A, 0, 32'h0000_0101);
    modl("sq_after_chain", 7, 0, 0);

    hand("init_b", 0, 0, 0, 32'h0);
    hand("simple_full", 1, A, 0, 32'h0);
    hand("sq_full", 7, 0, 0, 32'h1234_5779);
    hand("init_c", 0, 0, 0, 32'h0);
    hand("simple_inc1", 2, 32'hAABB_CC42, 1, 32'h0);
    hand("sq_inc1", 7, 0, 0, 32'h0000_0042);

    // Round trips: encrypt and decrypt from identical states.
    hand("init_d", 0, 0, 0, 32'h0);
    hand("enc_full0", 3, P, 0, P);
    hand("sq_enc_full0", 7, 0, 0, 32'hDEAD_BFEE);
    hand("init_e", 0, 0, 0, 32'h0);
    hand("dec_full0", 5, P, 0, P);
    hand("sq_dec_full0", 7, 0, 0, 32'hDEAD_BFEE);

    hand("init_f", 0, 0, 0, 32'h0);
    hand("absorb_a1", 1, A, 0, 32'h0);
    hand("enc_full", 3, P, 0, 32'hCC99_E996);
    modl("sq_enc_full", 7, 0, 0);
    hand("init_g", 0, 0, 0, 32'h0);
    hand("absorb_a2", 1, A, 0, 32'h0);
    hand("dec_full", 5, 32'hCC99_E996, 0, P);
    modl("sq_dec_full", 7, 0, 0);

    hand("init_h", 0, 0, 0, 32'h0);
    hand("enc_n1", 4, P, 1, 32'h0000_00EF);
    hand("sq_enc_n1", 7, 0, 0, 32'h0000_00EF);
    hand("init_i", 0, 0, 0, 32'h0);
    hand("dec_n1", 6, 32'h1234_56EF, 1, 32'h0000_00EF);
    hand("sq_dec_n1", 7, 0, 0, 32'h0000_00EF);

    hand("init_j", 0, 0, 0, 32'h0);
    hand("enc_n3_zero", 4, P, 3, 32'h00AD_BEEF);
    hand("sq_enc_n3_zero", 7, 0, 0, 32'h01AD_BFEF);
    hand("init_k", 0, 0, 0, 32'h0);
    hand("absorb_a3", 1, A, 0, 32'h0);
    hand("enc_n3", 4, P, 3, 32'h0099_E996);
    modl("sq_enc_n3", 7, 0, 0);
    hand("init_l", 0, 0, 0, 32'h0);
    hand("absorb_a4", 1, A, 0, 32'h0);
    hand("dec_n3", 6, 32'h5599_E996, 3, 32'h00AD_BEEF);
    modl("sq_dec_n3", 7, 0, 0);

    // Busy strobe dropped, illegal code ignored.
    hand("init_m", 0, 0, 0, 32'h0);
    cmd("sq_busy_hold", 7, 0, 0, 1'b1, 32'h0, 1'b1);
    hand("sq_after_busy", 7, 0, 0, 32'h0000_0101);
    modl("illegal_a", 4'hA, 32'hFFFF_FFFF, 3);
    hand("sq_after_illegal_out", 1, 32'h0, 0, 32'h0000_0101);
    modl("sq_after_illegal", 7, 0, 0);

    // Hash-style absorb of message 00 01 02 03, blanks, then squeezes.
    hand("init_n", 0, 0, 0, 32'h0);
    for (int b = 0; b < 4; b++) begin
      modl("hash_byte", 2, {24'h000001, 8'(b)}, 1);
      modl("hash_blank", 2, 32'h1, 0);
    end
    for (int k = 0; k < 2; k++) modl("hash_blank_tail", 2, 32'h1, 0);
    for (int k = 0; k < 4; k++) modl("hash_squeeze", 7, 0, 0);

    // Reset in the busy cycle.
    hand("init_o", 0, 0, 0, 32'h0);
    hand("sq_pre_rst0", 7, 0, 0, 32'h0);
    hand("sq_pre_rst1", 7, 0, 0, 32'h0000_0101);
    start_operation = 1'b1;
    operation_type  = 4'd7;
    buffer_in       = 32'h0;
    buffer_in_size  = 2'd0;
    @(posedge clk); #2;
    start_operation = 1'b0;
    check("midop_busy", {31'b0, core_free}, 32'd0);
    arst = 1'b1;
    #1;
    check("midop_rst_out", buffer_out, 32'h0);
    check("midop_rst_free", {31'b0, core_free}, 32'd1);
    check("midop_rst_finish", {31'b0, core_finish}, 32'd0);
    @(posedge clk); #2;
    arst  = 1'b0;
    m_s   = '0;
    m_out = '0;
    hand("sq_post_rst0", 7, 0, 0, 32'h0);
    hand("sq_post_rst1", 7, 0, 0, 32'h0000_0101);

    repeat (3) begin @(posedge clk); #2; end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/subterranean_duplex_core.md
SUBTERRANEAN_DUPLEX_CORE -- requirements
Module: subterranean_simple_no_communication

Interface
REQ-001 The design SHALL have one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 arst  input  1  asynchronous active-high reset.
REQ-004 start_operation  input  1  one-cycle command strobe, sampled only while core_free=1.
REQ-005 operation_type  input  4  command code, sampled with start_operation.
REQ-006 buffer_in  input  32  data block, little-endian bit order (byte 0 = bits 7:0), sampled with start_operation.
REQ-007 buffer_in_size  input  2  number of valid data bytes (0-3), used only by the incomplete commands.
REQ-008 buffer_out  output  32  registered result word.
REQ-009 core_free  output  1  high when the core is idle and accepting a command.
REQ-010 core_finish  output  1  one-cycle pulse when a command completes.

Function
REQ-011 State SHALL be a 257-bit register s[0..256]; all indices are taken mod 257.
REQ-012 Round R SHALL apply the following steps in order, each using the previous step's result:
- chi: s_i ^= ~s_{i+1} & s_{i+2};
- iota: s_0 ^= 1;
- theta: s_i ^= s_{i+3} ^ s_{i+8};
- pi: s_i = s_{12i}.
REQ-013 duplex(sigma), with sigma 33 bits: apply R, then s[12^(4j) mod 257] ^= sigma_j for j=0..32.
REQ-014 extract: z_i = s[12^(4i) mod 257] ^ s[-12^(4i) mod 257] for i=0..31; z_0 is buffer_out bit 0.
REQ-015 Full padding: sigma = {1, X[31:0]}.
REQ-016 Incomplete padding, n = buffer_in_size:
- sigma bits 8n-1..0 = X;
- sigma bit 8n = 1;
- all higher sigma bits = 0;
- buffer_in bits at and above 8n are ignored.
REQ-017 Command 0 (init): s = 0; buffer_out = 0.
REQ-018 Command 1 (simple full): duplex(full pad of buffer_in); buffer_out unchanged.
REQ-019 Command 2 (simple incomplete): duplex(incomplete pad of buffer_in, n); buffer_out unchanged.
REQ-020 Command 3 (encrypt full): z = extract (before the round); buffer_out = buffer_in ^ z; duplex(full pad of buffer_in).
REQ-021 Command 4 (encrypt incomplete): as command 3 with incomplete pad; buffer_out bytes >= n SHALL be 0.
REQ-022 Command 5 (decrypt full): X = buffer_in ^ extract; buffer_out = X; duplex(full pad of X).
REQ-023 Command 6 (decrypt incomplete): as command 5; X is masked to n bytes before padding and output.
REQ-024 Command 7 (squeeze): buffer_out = extract; then duplex(incomplete pad, n=0), i.e. sigma = 1.
REQ-025 Commands 8-15 SHALL be ignored: no state change, no core_finish pulse, core_free stays high.
REQ-026 Timing:
- the edge sampling start_operation=1 with core_free=1 latches the command and drives core_free low;
- the next edge updates s and buffer_out, pulses core_finish for one cycle, and returns core_free high.
REQ-027 start_operation while core_free=0 SHALL be ignored.
REQ-028 buffer_out SHALL hold its value until a later command overwrites it.
REQ-029 The permutation SHALL be purely combinational, one round per command.

Reset
REQ-030 While arst=1:
- s = 0 and buffer_out = 0;
- core_free = 1 and core_finish = 0;
- any pending command is discarded.
REQ-031 Deasserting arst returns the core to idle; the next start_operation is accepted on the first following edge.

Verification
REQ-032 Reset, then init, then squeeze -> buffer_out = 0x00000000, core_finish pulses once per command, and core_free is low for exactly one cycle per command.
REQ-033 Hash of the empty message:
- stimulus: init; simple incomplete(0x1, n=0) x2; simple incomplete(0x1, n=0) x8; squeeze x8, collecting buffer_out words least-significant-first into 256 bits;
- required response: the Subterranean v1 hash KAT digest for the empty message.
REQ-034 Hash of a non-empty message:
- stimulus: init; per byte b, simple incomplete({0x000001, b}, n=1) then simple incomplete(0x1, n=0); then the same blank and squeeze sequence as REQ-033;
- required response: the KAT digest for the message 00 01 02 ... .
REQ-035 Encrypt/decrypt round trip:
- stimulus: from identical states, apply encrypt full(P=0xDEADBEEF) and decrypt full(C);
- required response: decrypt returns 0xDEADBEEF and both final states are equal;
- repeat with n=1 and n=3, checking that the masked upper bytes are 0.
REQ-036 Busy handling: a start_operation issued while core_free=0 -> no effect; an illegal code 0xA -> no core_finish pulse and state unchanged.
REQ-037 Reset mid-operation: assert arst in the busy cycle -> outputs return to their reset values immediately; a following squeeze returns 0.
